// File: rtl/taint_ram_pkg.sv
// rtl/taint_ram_pkg.sv - shared state encoding, limits and byte-mask helper for the taint RAM
package taint_ram_pkg;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } ram_state_e;

  localparam int MaxReadLatency = 4;
  localparam int MaxWidth       = 1024;
  localparam int MaxBytes       = MaxWidth / 8;

  // Widens each byte enable over its 8 data bits; callers keep the low Width bits.
  function automatic logic [MaxWidth-1:0] byte_mask_expand(input logic [MaxBytes-1:0] be);
    logic [MaxWidth-1:0] mask;
    mask = '0;
    for (int b = 0; b < MaxBytes; b++) begin
      mask[b*8 +: 8] = {8{be[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/taint_ram_rd_pipe.sv
// rtl/taint_ram_rd_pipe.sv - fixed-depth read return pipe carrying valid, err, data and taint planes
module taint_ram_rd_pipe #(
  parameter int Width     = 32,
  parameter int NumTaints = 1,
  parameter int Stages    = 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            in_valid,
  input  logic                            in_err,
  input  logic [Width-1:0]                in_data,
  input  logic [NumTaints-1:0][Width-1:0] in_taint,
  output logic                            out_valid,
  output logic                            out_err,
  output logic [Width-1:0]                out_data,
  output logic [NumTaints-1:0][Width-1:0] out_taint
);

  logic [Stages-1:0]               valid_q;
  logic [Stages-1:0]               err_q;
  logic [Width-1:0]                data_q  [Stages];
  logic [NumTaints-1:0][Width-1:0] taint_q [Stages];

  // Payload only moves with a valid beat, so the last stage holds between reads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int s = 0; s < Stages; s++) begin
        data_q[s]  <= '0;
        taint_q[s] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      err_q[0]   <= in_err;
      if (in_valid) begin
        data_q[0]  <= in_data;
        taint_q[0] <= in_taint;
      end
      for (int s = 1; s < Stages; s++) begin
        valid_q[s] <= valid_q[s-1];
        err_q[s]   <= err_q[s-1];
        if (valid_q[s-1]) begin
          data_q[s]  <= data_q[s-1];
          taint_q[s] <= taint_q[s-1];
        end
      end
    end
  end

  assign out_valid = valid_q[Stages-1];
  assign out_err   = err_q[Stages-1];
  assign out_data  = data_q[Stages-1];
  assign out_taint = taint_q[Stages-1];

endmodule

// File: rtl/taint_ram_mem.sv
// rtl/taint_ram_mem.sv - single-port RAM with parallel taint planes and post-reset taint sweep
// Optional TAINT_RAM_ADDR_TAINT_WRITE_EN: tainted address/control poisons whole written word.
module taint_ram_mem
  import taint_ram_pkg::*;
#(
  parameter int Width       = 32,
  parameter int AddrWidth   = 10,
  parameter int NumTaints   = 1,
  parameter int ReadLatency = 1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              req_i,
  output logic                              gnt_o,
  input  logic                              we_i,
  input  logic [31:0]                       addr_i,
  input  logic [Width/8-1:0]                be_i,
  input  logic [Width-1:0]                  wdata_i,
  output logic                              rvalid_o,
  output logic [Width-1:0]                  rdata_o,
  output logic                              err_o,
  input  logic [NumTaints-1:0]              req_t0,
  input  logic [NumTaints-1:0]              we_t0,
  input  logic [NumTaints-1:0][31:0]        addr_t0,
  input  logic [NumTaints-1:0][Width/8-1:0] be_t0,
  input  logic [NumTaints-1:0][Width-1:0]   wdata_t0,
  output logic [NumTaints-1:0][Width-1:0]   rdata_t0
);

  localparam int Depth    = 1 << AddrWidth;
  localparam int NumBytes = Width / 8;
  localparam int Latency  = (ReadLatency < 1) ? 1 :
                            (ReadLatency > MaxReadLatency) ? MaxReadLatency : ReadLatency;

  localparam logic [0:0] StInit  = INIT;
  localparam logic [0:0] StReady = READY;

  logic [0:0]                      state_q;
  logic [AddrWidth-1:0]            init_cnt_q;
  logic [Width-1:0]                mem_q       [Depth];
  logic [NumTaints-1:0][Width-1:0] taint_mem_q [Depth];

  logic                            in_range;
  logic [AddrWidth-1:0]            idx;
  logic                            wr_en;
  logic                            rd_en;
  logic [NumTaints-1:0]            at;
  logic [MaxWidth-1:0]             be_mask_full;
  logic [Width-1:0]                be_mask;
  logic                            unused_mask_hi;
  logic [Width-1:0]                mem_rd;
  logic [Width-1:0]                wr_data;
  logic [Width-1:0]                rd_data;
  logic [NumTaints-1:0][Width-1:0] taint_rd;
  logic [NumTaints-1:0][Width-1:0] wr_taint;
  logic [NumTaints-1:0][Width-1:0] rd_taint;

  assign in_range = (addr_i[31:AddrWidth] == '0);
  assign idx      = addr_i[AddrWidth-1:0];
  assign gnt_o    = req_i & (state_q == StReady) & ~rst_i;
  assign wr_en    = gnt_o & we_i & in_range;
  assign rd_en    = gnt_o & ~we_i;

  assign be_mask_full   = byte_mask_expand(MaxBytes'(be_i));
  assign be_mask        = be_mask_full[Width-1:0];
  assign unused_mask_hi = ^be_mask_full[MaxWidth-1:Width];

  assign mem_rd   = mem_q[idx];
  assign taint_rd = taint_mem_q[idx];
  assign wr_data  = (mem_rd & ~be_mask) | (wdata_i & be_mask);
  assign rd_data  = in_range ? mem_rd : '0;

  always_comb begin
    logic [Width-1:0] bet_mask;
    at       = '0;
    wr_taint = '0;
    rd_taint = '0;
    bet_mask = '0;
    for (int k = 0; k < NumTaints; k++) begin
      at[k] = (|addr_t0[k]) | req_t0[k] | we_t0[k];
      for (int b = 0; b < NumBytes; b++) begin
        bet_mask[b*8 +: 8] = {8{be_t0[k][b]}};
      end
      // A tainted byte enable may have fired, so that byte is fully tainted either way.
      wr_taint[k] = (taint_rd[k] & ~be_mask) | (wdata_t0[k] & be_mask) | bet_mask;
`ifdef TAINT_RAM_ADDR_TAINT_WRITE_EN
      if (at[k]) begin
        wr_taint[k] = '1;
      end
`endif
      rd_taint[k] = (in_range ? taint_rd[k] : '0) | {Width{at[k]}};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
    end else if (state_q == StInit) begin
      init_cnt_q <= init_cnt_q + AddrWidth'(1);
      if (&init_cnt_q) begin
        state_q <= StReady;
      end
    end
  end

  // Data words survive reset; only the taint planes are swept clean.
  always_ff @(posedge clk_i) begin
    if (state_q == StInit) begin
      taint_mem_q[init_cnt_q] <= '0;
    end else if (wr_en) begin
      mem_q[idx]       <= wr_data;
      taint_mem_q[idx] <= wr_taint;
    end
  end

  taint_ram_rd_pipe #(
    .Width     (Width),
    .NumTaints (NumTaints),
    .Stages    (Latency)
  ) u_rd_pipe (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .in_valid  (rd_en),
    .in_err    (rd_en & ~in_range),
    .in_data   (rd_data),
    .in_taint  (rd_taint),
    .out_valid (rvalid_o),
    .out_err   (err_o),
    .out_data  (rdata_o),
    .out_taint (rdata_t0)
  );

endmodule
